// File: rtl/dtc_pkg.sv
// Shared constants and the per-level pipeline record for the programmable decision-tree
// classifier.
package dtc_pkg;

    localparam int unsigned N_FEAT  = 12;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CLASS_W = 1;
    localparam int unsigned FIDX_W  = $clog2(N_FEAT);
    localparam int unsigned CFG_W   = (FIDX_W > CLASS_W) ? FIDX_W : CLASS_W;
    localparam int unsigned N_LEAF  = 2 ** DEPTH;

    // idx is wide enough for the child index leaving the last level.
    typedef struct packed {
        logic              valid;
        logic [N_FEAT-1:0] feat;
        logic [DEPTH:0]    idx;
    } stage_t;

    // Heap descent: left child is 2*idx, right child is 2*idx+1.
    function automatic logic [DEPTH:0] child_idx(input logic [DEPTH:0] idx, input logic b);
        return (idx << 1) | {{DEPTH{1'b0}}, b};
    endfunction

endpackage

// File: rtl/dtc_level_stage.sv
// One tree level: holds a sample, looks up its node's feature index and descends one level.
module dtc_level_stage
    import dtc_pkg::*;
#(
    parameter int unsigned LEVEL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  stage_t            d,
    input  logic [FIDX_W-1:0] node_tab [N_LEAF],
    output stage_t            nxt,
    output logic              vld
);

    stage_t            q;
    logic [DEPTH-1:0]  node;
    logic [FIDX_W-1:0] fsel;
    logic              b;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

    // At this level only the low LEVEL+1 index bits can be non-zero.
    always_comb begin
        node    = DEPTH'(q.idx[LEVEL:0]);
        fsel    = node_tab[node];
        b       = q.feat[fsel];
        nxt     = q;
        nxt.idx = child_idx(q.idx, b);
    end

    assign vld = q.valid;

endmodule

// File: rtl/dtc_pipe_classifier.sv
// Pipelined binary decision-tree classifier with run-time programmable node and leaf tables;
// one tree level per stage, valid/ready on both sides.
module dtc_pipe_classifier
    import dtc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_FEAT-1:0]  inp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CLASS_W-1:0] outp,
    input  logic               cfg_we,
    input  logic               cfg_leaf,
    input  logic [DEPTH-1:0]   cfg_addr,
    input  logic [CFG_W-1:0]   cfg_data,
    output logic               cfg_err,
    output logic               busy
);

    localparam logic [DEPTH:0] ROOT_IDX = 'd1;

    logic [FIDX_W-1:0]  node_tab [N_LEAF];
    logic [CLASS_W-1:0] leaf_tab [N_LEAF];
    stage_t             chain    [DEPTH+1];
    logic [DEPTH-1:0]   stage_vld;
    logic               en;
    logic               cfg_ok;
    logic               unused_last;

    // Every stage advances together; a stalled output freezes the whole pipe.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign busy     = (|stage_vld) || out_valid;

    assign chain[0] = '{valid: in_valid, feat: inp, idx: ROOT_IDX};

    for (genvar s = 0; s < DEPTH; s++) begin : g_level
        dtc_level_stage #(
            .LEVEL(s)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .d        (chain[s]),
            .node_tab (node_tab),
            .nxt      (chain[s+1]),
            .vld      (stage_vld[s])
        );
    end

    // Past the last level only the leaf number matters.
    assign unused_last = ^{chain[DEPTH].feat, chain[DEPTH].idx[DEPTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            outp      <= '0;
        end else if (en) begin
            out_valid <= chain[DEPTH].valid;
            if (chain[DEPTH].valid) begin
                outp <= leaf_tab[chain[DEPTH].idx[DEPTH-1:0]];
            end
        end
    end

    // A sample offered in the same cycle always beats a table write.
    always_comb begin
        cfg_ok = !busy && !in_valid;
        if (!cfg_leaf && (cfg_addr == '0 || 32'(cfg_data) >= N_FEAT)) begin
            cfg_ok = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LEAF; i++) begin
                node_tab[i] <= '0;
                leaf_tab[i] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            if (cfg_we && cfg_ok) begin
                if (cfg_leaf) begin
                    leaf_tab[cfg_addr] <= cfg_data[CLASS_W-1:0];
                end else begin
                    node_tab[cfg_addr] <= cfg_data[FIDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_dtc_pipe_classifier.sv
// Self-checking bench for dtc_pipe_classifier: tree-walk reference model plus in-order scoreboard.
module tb_dtc_pipe_classifier;
    import dtc_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [N_FEAT-1:0]  inp;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] outp;
    logic               cfg_we;
    logic               cfg_leaf;
    logic [DEPTH-1:0]   cfg_addr;
    logic [CFG_W-1:0]   cfg_data;
    logic               cfg_err;
    logic               busy;

    always #5 clk = ~clk;

    dtc_pipe_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inp       (inp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outp      (outp),
        .cfg_we    (cfg_we),
        .cfg_leaf  (cfg_leaf),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference tables: node n tests feature m_node[n]; leaf k holds m_leaf[k].
    int m_node [N_LEAF];
    int m_leaf [N_LEAF];
    int exp_q  [$];

    int bm7_node [8] = '{0, 0, 9, 5, 1, 11, 10, 2};
    int bm7_leaf [8] = '{0, 1, 1, 0, 1, 0, 0, 1};

    int n_acc = 0;
    int n_out = 0;
    bit track = 1'b0;
    int first_out_cyc = -1;
    int last_out_cyc  = -1;
    int gaps = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int model(input logic [N_FEAT-1:0] x);
        int n = 1;
        for (int l = 0; l < DEPTH; l++) begin
            n = 2 * n + int'(x[m_node[n]]);
        end
        return m_leaf[n - N_LEAF];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_LEAF; i++) begin
            m_node[i] = 0;
            m_leaf[i] = 0;
        end
        exp_q.delete();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Handshakes are judged mid-cycle, where inputs and outputs are settled.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(inp));
                n_acc++;
            end
            if (out_valid && out_ready) begin
                check_eq("output_has_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check_eq("class", int'(outp), exp_q.pop_front());
                end
                if (track) begin
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    else if (cyc != last_out_cyc + 1) gaps++;
                    last_out_cyc = cyc;
                end
                n_out++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input bit leaf, input int addr, input int data, input bit ok,
                             input string tag);
        cfg_we   = 1'b1;
        cfg_leaf = leaf;
        cfg_addr = DEPTH'(addr);
        cfg_data = CFG_W'(data);
        tick();
        cfg_we = 1'b0;
        check_eq({tag, "_err"}, int'(cfg_err), ok ? 0 : 1);
        if (ok) begin
            if (leaf) m_leaf[addr] = data;
            else m_node[addr] = data;
        end
        tick();
        check_eq({tag, "_err_clear"}, int'(cfg_err), 0);
    endtask

    task automatic wait_drain(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (exp_q.size() == 0 && !busy) done = 1'b1;
            else tick();
        end
        check_eq({tag, "_drained"}, int'(done), 1);
    endtask

    task automatic send_burst(input int n);
        in_valid = 1'b1;
        for (int k = 0; k < n; k++) begin
            inp = N_FEAT'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_one_expect(input logic [N_FEAT-1:0] x, input int cls, input string tag);
        bit seen = 1'b0;
        inp      = x;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check_eq({tag, "_seen"}, int'(seen), 1);
        if (seen) check_eq({tag, "_class"}, int'(outp), cls);
        tick();
    endtask

    initial begin
        int t0;
        int lat;
        int acc;
        int base;
        bit fired;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; inp = '0;
        cfg_we = 1'b0; cfg_leaf = 1'b0; cfg_addr = '0; cfg_data = '0;
        model_reset();
        #1;
        check_eq("in_ready_in_rst", int'(in_ready), 0);
        tick();
        tick();
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_outp", int'(outp), 0);
        check_eq("rst_cfg_err", int'(cfg_err), 0);
        rst = 1'b0;
        #1;
        check_eq("in_ready_idle", int'(in_ready), 1);

        // bm7 is three levels deep; each leaf is duplicated under the extra level.
        for (int n = 1; n < 8; n++) cfg_write(1'b0, n, bm7_node[n], 1'b1, "cfg_node");
        for (int k = 0; k < N_LEAF; k++) cfg_write(1'b1, k, bm7_leaf[k/2], 1'b1, "cfg_leaf");

        // Single sample: presented in cycle t0, result visible five cycles later.
        inp = 12'h001; in_valid = 1'b1; t0 = cyc;
        tick();
        in_valid = 1'b0;
        check_eq("single_busy", int'(busy), 1);
        lat = -1;
        for (int k = 0; k < 20 && lat < 0; k++) begin
            if (out_valid) lat = cyc - t0;
            else tick();
        end
        check_eq("single_latency", lat, 5);
        check_eq("single_outp", int'(outp), model(12'h001));
        tick();
        check_eq("single_done_valid", int'(out_valid), 0);
        check_eq("single_done_busy", int'(busy), 0);

        // Exhaustive back-to-back stream.
        base = n_out; first_out_cyc = -1; gaps = 0; track = 1'b1;
        t0 = cyc; in_valid = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            inp = N_FEAT'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_drain("exhaustive");
        track = 1'b0;
        check_eq("exhaustive_count", n_out - base, 4096);
        check_eq("exhaustive_gaps", gaps, 0);
        check_eq("exhaustive_fill", first_out_cyc - t0, 5);

        // Output stall with continuous input.
        out_ready = 1'b0; in_valid = 1'b1; inp = N_FEAT'($urandom); acc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            fired = in_ready;
            if (fired) acc++;
            tick();
            if (fired) inp = N_FEAT'($urandom);
        end
        check_eq("stall_accepted", acc, 5);
        check_eq("stall_in_ready", int'(in_ready), 0);
        check_eq("stall_out_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            fired = in_ready;
            tick();
            if (fired) inp = N_FEAT'($urandom);
        end
        in_valid = 1'b0;
        wait_drain("stall");

        // Rejected writes must leave both tables untouched.
        inp = N_FEAT'($urandom); in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("busy_before_cfg", int'(busy), 1);
        cfg_write(1'b0, 1, 3, 1'b0, "cfg_busy");
        wait_drain("cfg_busy");
        cfg_write(1'b0, 2, 12, 1'b0, "cfg_bad_feat");
        cfg_write(1'b0, 0, 1, 1'b0, "cfg_addr0");

        acc = n_acc;
        inp = N_FEAT'($urandom); in_valid = 1'b1;
        cfg_we = 1'b1; cfg_leaf = 1'b1; cfg_addr = 4'd4; cfg_data = CFG_W'(1 - m_leaf[4]);
        tick();
        in_valid = 1'b0; cfg_we = 1'b0;
        check_eq("simul_err", int'(cfg_err), 1);
        check_eq("simul_accept", n_acc - acc, 1);
        wait_drain("simul");
        send_one_expect(12'h200, bm7_leaf[2], "leaf4_kept");
        send_burst(64);
        wait_drain("unchanged");

        // Leaf 0 reprogram: an all-zero vector always walks left to leaf 0.
        send_one_expect(12'h000, 0, "leaf0_old");
        cfg_write(1'b1, 0, 1, 1'b1, "cfg_leaf0");
        send_one_expect(12'h000, 1, "leaf0_new");

        // Reset with three samples in flight.
        send_burst(3);
        check_eq("inflight_busy", int'(busy), 1);
        rst = 1'b1;
        tick();
        check_eq("midrst_out_valid", int'(out_valid), 0);
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_outp", int'(outp), 0);
        rst = 1'b0;
        model_reset();
        send_one_expect(12'h000, 0, "leaf0_after_rst");

        // Random tables and random traffic with output back-pressure.
        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 8; w++) begin
                if ($urandom_range(1, 0) == 1)
                    cfg_write(1'b1, $urandom_range(N_LEAF - 1, 0), $urandom_range(1, 0), 1'b1,
                              "cfg_rand_leaf");
                else
                    cfg_write(1'b0, $urandom_range(N_LEAF - 1, 1), $urandom_range(N_FEAT - 1, 0),
                              1'b1, "cfg_rand_node");
            end
            for (int k = 0; k < 200; k++) begin
                in_valid  = ($urandom_range(3, 0) != 0);
                out_ready = ($urandom_range(3, 0) != 0);
                inp       = N_FEAT'($urandom);
                tick();
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            wait_drain("random");
        end

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
